// File: rtl/cpu_controller.sv
// Instruction register plus Moore sequencer that drives every datapath control input.
// Optional build macro CTRL_ILLEGAL_EN adds a sticky `illegal` output flag.
module cpu_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [15:0] datapath_in,
    output logic        vsel,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [2:0]  readnum,
    output logic        loada,
    output logic        loadb,
    output logic [1:0]  shift,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads
`ifdef CTRL_ILLEGAL_EN
    ,
    output logic        illegal
`endif
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    typedef struct packed {
        logic       w;
        logic       vsel;
        logic [2:0] writenum;
        logic       write;
        logic [2:0] readnum;
        logic       loada;
        logic       loadb;
        logic [1:0] shift;
        logic       asel;
        logic       bsel;
        logic [1:0] aluop;
        logic       loadc;
        logic       loads;
    } ctrl_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d;

    function automatic logic is_mov_imm(input logic [15:0] ir);
        return ir[15:11] == 5'b11010;
    endfunction

    function automatic logic is_mov_reg(input logic [15:0] ir);
        return ir[15:11] == 5'b11000;
    endfunction

    function automatic logic is_mvn(input logic [15:0] ir);
        return ir[15:11] == 5'b10111;
    endfunction

    function automatic logic is_cmp(input logic [15:0] ir);
        return ir[15:11] == 5'b10101;
    endfunction

    function automatic logic is_two_op(input logic [15:0] ir);
        return (ir[15:11] == 5'b10100) || (ir[15:11] == 5'b10110);
    endfunction

    // Where DECODE goes next; S_WAIT means the encoding is illegal.
    function automatic state_t dispatch(input logic [15:0] ir);
        state_t nxt;
        if (is_mov_imm(ir)) begin
            nxt = S_WRITE_IMM;
        end else if (is_mov_reg(ir) || is_mvn(ir)) begin
            nxt = S_GET_B;
        end else if (is_two_op(ir) || is_cmp(ir)) begin
            nxt = S_GET_A;
        end else begin
            nxt = S_WAIT;
        end
        return nxt;
    endfunction

    // Moore output decode for a given state and instruction.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [15:0] ir);
        ctrl_t c;
        c          = '0;
        c.readnum  = ir[2:0];
        c.writenum = ir[7:5];
        case (st)
            S_WAIT: begin
                c.w = 1'b1;
            end
            S_WRITE_IMM: begin
                c.vsel     = 1'b1;
                c.write    = 1'b1;
                c.writenum = ir[10:8];
            end
            S_GET_A: begin
                c.readnum = ir[10:8];
                c.loada   = 1'b1;
            end
            S_GET_B: begin
                c.loadb = 1'b1;
            end
            S_ALU: begin
                c.shift = ir[4:3];
                if (is_mov_reg(ir)) begin
                    c.asel  = 1'b1;
                    c.aluop = 2'b00;
                end else begin
                    c.asel  = 1'b0;
                    c.aluop = ir[12:11];
                end
                if (is_cmp(ir)) begin
                    c.loads = 1'b1;
                end else begin
                    c.loadc = 1'b1;
                end
            end
            S_WRITE_REG: begin
                c.write = 1'b1;
            end
            default: begin
                c.w = 1'b0;
            end
        endcase
        return c;
    endfunction

    // Next-state and IR-capture logic; outputs are pre-decoded from the next state.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (load) begin
                    ir_d = in;
                end else begin
                    ir_d = ir_q;
                end
                if (s) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DECODE:    state_d = dispatch(ir_q);
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU: begin
                if (is_cmp(ir_q)) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_WRITE_REG;
                end
            end
            S_WRITE_REG: state_d = S_WAIT;
            S_WRITE_IMM: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
        ctrl_d = decode_ctrl(state_d, ir_d);
    end

`ifdef CTRL_ILLEGAL_EN
    logic illegal_q, illegal_d;

    // Sticky flag: set leaving DECODE on a bad encoding, cleared when the next start is accepted.
    always_comb begin
        illegal_d = illegal_q;
        if ((state_q == S_DECODE) && (dispatch(ir_q) == S_WAIT)) begin
            illegal_d = 1'b1;
        end else if ((state_q == S_WAIT) && s) begin
            illegal_d = 1'b0;
        end else begin
            illegal_d = illegal_q;
        end
    end

    assign illegal = illegal_q;
`endif

    // State, instruction register and registered control outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_WAIT;
            ir_q      <= 16'h0000;
            ctrl_q    <= decode_ctrl(S_WAIT, 16'h0000);
`ifdef CTRL_ILLEGAL_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            ctrl_q    <= ctrl_d;
`ifdef CTRL_ILLEGAL_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign datapath_in = {{8{ir_q[7]}}, ir_q[7:0]};
    assign w           = ctrl_q.w;
    assign vsel        = ctrl_q.vsel;
    assign writenum    = ctrl_q.writenum;
    assign write       = ctrl_q.write;
    assign readnum     = ctrl_q.readnum;
    assign loada       = ctrl_q.loada;
    assign loadb       = ctrl_q.loadb;
    assign shift       = ctrl_q.shift;
    assign asel        = ctrl_q.asel;
    assign bsel        = ctrl_q.bsel;
    assign ALUop       = ctrl_q.aluop;
    assign loadc       = ctrl_q.loadc;
    assign loads       = ctrl_q.loads;

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Instruction register plus Moore FSM that sits directly upstream of the datapath and drives every datapath control input.
- Latches a 16-bit instruction, waits for start, then sequences register reads, ALU, status and writeback over several cycles.
- Signals completion with `w`.
- Owns the immediate path: sign-extended imm8 is presented on `datapath_in` for MOV-immediate.

Parameters:
- (none)

Ports:
- clk          input   1   rising-edge clock shared with datapath
- reset_n      input   1   asynchronous active-low reset
- s            input   1   start; sampled only in WAIT
- load         input   1   IR load enable; honoured only in WAIT
- in           input   16  instruction word
- w            output  1   1 only in WAIT (ready for s)
- datapath_in  output  16  {{8{IR[7]}},IR[7:0]} (sximm8), combinational from IR
- vsel         output  1   1 = write datapath_in, 0 = write C
- writenum     output  3   regfile write index
- write        output  1   regfile write enable
- readnum      output  3   regfile read index
- loada        output  1   A register enable
- loadb        output  1   B register enable
- shift        output  2   shifter op
- asel         output  1   1 = Ain forced 0
- bsel         output  1   1 = Bin from datapath_in[4:0]; always 0 in this ISA subset
- ALUop        output  2   00 add, 01 sub, 10 and, 11 not-B
- loadc        output  1   C register enable
- loads        output  1   status register enable

Behaviour:
- Decode fields:
  - opcode = IR[15:13], op = IR[12:11]
  - Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0]
- Supported encodings:
  - MOV Rn,#imm8 = 110/10
  - MOV Rd,Rm{,sh} = 110/00
  - ADD = 101/00, CMP = 101/01, AND = 101/10, MVN = 101/11
  - All others are illegal.
- IR:
  - 16-bit register, loaded from `in` on a clk edge when load=1 and state=WAIT.
  - Held otherwise.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG. Registered state; all control outputs are decoded from state+IR (Moore, no s/load feed-through).
- Transitions:
  - WAIT → DECODE if s=1, else stay.
  - If load=1 and s=1 on the same edge, the IR captures the new word and DECODE uses it.
  - DECODE → WRITE_IMM (MOV imm), GET_B (MOV reg, MVN), GET_A (ADD/CMP/AND), WAIT (illegal).
  - GET_A → GET_B → ALU.
  - ALU → WAIT for CMP, else → WRITE_REG.
  - WRITE_REG → WAIT.
  - WRITE_IMM → WAIT.
- Per-state asserted outputs (anything unlisted is 0):
  - WAIT: w=1.
  - WRITE_IMM: vsel=1, write=1, writenum=Rn.
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - ALU:
    - shift=sh, bsel=0.
    - asel=1 and ALUop=00 for MOV reg; otherwise asel=0 and ALUop=op.
    - loads=1 for CMP only; loadc=1 for all others.
  - WRITE_REG: vsel=0, write=1, writenum=Rd.
- Index defaults when not in the states above: readnum=Rm, writenum=Rd.
- Latency, counted from the edge k that samples s=1 in WAIT:
  - MOV imm: regfile write at edge k+2; w=1 after k+2.
  - MOV reg / MVN: write at k+4.
  - ADD / AND: write at k+5.
  - CMP: status loaded at k+4; no regfile write; w=1 after k+4.
  - Illegal: w=1 after k+1; no enables asserted.
- s during non-WAIT states is ignored; no queuing. load outside WAIT is ignored.
- Reset (any time, including mid-sequence): state=WAIT and IR=0 immediately.
  - All enables drop to 0 asynchronously; w=1.
  - An in-flight instruction is abandoned with no further writes.
  - IR=0 decodes as illegal.

Optional Feature:
- Macro: CTRL_ILLEGAL_EN.
- When defined:
  - Adds output `illegal` (1 bit), a sticky register.
  - Set on the edge leaving DECODE with an illegal encoding.
  - Cleared on the edge that accepts the next s in WAIT, or by reset (reset value 0).
- When undefined: the port is absent and illegal encodings silently return to WAIT.

Test Plan:
- Reset then load IR=16'hD2FB (MOV R2,#-5), pulse s:
  - write=1, vsel=1, writenum=2 exactly one cycle, two cycles after s.
  - datapath_in=16'hFFFB.
  - w=1 the cycle after.
- IR=16'hA0A9 (ADD R5,R0,R1,LSL1), s:
  - GET_A: readnum=0, loada=1.
  - GET_B: readnum=1, loadb=1.
  - ALU: shift=01, ALUop=00, loadc=1.
  - WRITE_REG: writenum=5, write=1.
  - w high again 5 edges after s.
- IR=16'hAB01 (CMP R3,R1), s:
  - ALU state has loads=1, loadc=0, ALUop=01.
  - write never asserts; w returns after 4 edges.
- IR=16'hC0E4 (MOV R7,R4), s:
  - No loada.
  - ALU state has asel=1, ALUop=00, shift=00.
  - WRITE_REG writenum=7.
- Start ADD, deassert reset_n during ALU state:
  - Outputs go 0 and w=1 without waiting for clk.
  - After release, IR=0; s → back to WAIT in 2 edges with no writes (illegal=1 if CTRL_ILLEGAL_EN).
- While mid-ADD, pulse load with 16'hD101 and s:
  - IR unchanged; instruction completes with original Rd.
  - No restart.
